// File: rtl/tt_sweep.sv
// Truth-table sweeper: steps x_out through every input vector, samples y_in after a
// settle time, and compares the captured table against a golden copy latched at start.
//
// state   | meaning
// IDLE    | waiting for start, results from the last sweep held
// RUN     | driving x_out = idx, sampling y_in after SETTLE cycles per vector
// DONE    | one-cycle completion pulse, match valid
module tt_sweep #(
  parameter int N_IN   = 5,
  parameter int SETTLE = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 abort,
  input  logic [2**N_IN-1:0]   golden,
  output logic [N_IN-1:0]      x_out,
  input  logic                 y_in,
  output logic                 busy,
  output logic                 done,
  output logic [2**N_IN-1:0]   tt,
  output logic                 match,
  output logic [N_IN:0]        mismatch_cnt,
  output logic [N_IN-1:0]      first_fail_idx,
  output logic                 first_fail_vld
);

  localparam int NV = 2**N_IN;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic [3:0]      SETTLE_LAST = 4'(SETTLE - 1);
  localparam logic [N_IN-1:0] IDX_LAST    = N_IN'(NV - 1);

  logic [1:0]      state;
  logic [NV-1:0]   golden_q;
  logic [N_IN-1:0] idx;
  logic [3:0]      settle_cnt;
  logic            miss;
  logic            last_idx;

  assign miss     = (y_in != golden_q[idx]);
  assign last_idx = (idx == IDX_LAST);

  assign x_out = (state == ST_RUN) ? idx : '0;
  assign busy  = (state != ST_IDLE);
  assign done  = (state == ST_DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= ST_IDLE;
      golden_q       <= '0;
      idx            <= '0;
      settle_cnt     <= '0;
      tt             <= '0;
      match          <= 1'b0;
      mismatch_cnt   <= '0;
      first_fail_idx <= '0;
      first_fail_vld <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            golden_q       <= golden;
            tt             <= '0;
            mismatch_cnt   <= '0;
            first_fail_vld <= 1'b0;
            match          <= 1'b0;
            idx            <= '0;
            settle_cnt     <= '0;
            state          <= ST_RUN;
          end
        end
        ST_RUN: begin
          // abort wins over a sample on the same edge, including the final one
          if (abort) begin
            state <= ST_IDLE;
          end else if (settle_cnt == SETTLE_LAST) begin
            tt[idx] <= y_in;
            if (miss) begin
              mismatch_cnt <= mismatch_cnt + (N_IN+1)'(1);
              if (!first_fail_vld) begin
                first_fail_idx <= idx;
                first_fail_vld <= 1'b1;
              end
            end
            if (last_idx) begin
              match <= (mismatch_cnt == '0) && !miss;
              state <= ST_DONE;
            end else begin
              idx        <= idx + N_IN'(1);
              settle_cnt <= '0;
            end
          end else begin
            settle_cnt <= settle_cnt + 4'd1;
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tt_sweep.sv
// Scoreboarded random bench for tt_sweep: each start pushes the expected sweep result,
// a negedge monitor checks x_out/busy/done every cycle and pops on each done pulse.
module tb_tt_sweep;
  localparam int N  = 5;
  localparam int S  = 3;
  localparam int NV = 32;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic          y_in;
  logic [NV-1:0] golden = '0;
  logic [NV-1:0] blk_tt = '0;
  logic [NV-1:0] tt;
  logic [N-1:0]  x_out;
  logic [N-1:0]  ffi;
  logic          busy, done, match, ffv;
  logic [N:0]    cnt;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int exp_start = 0;
  bit exp_active = 1'b0;

  typedef struct {
    logic [31:0] tt;
    int          cnt;
    int          ffi;
    bit          ffv;
    int          dcyc;
  } exp_t;

  exp_t sbq[$];

  bit   m_run, m_done;
  int   m_x;
  exp_t m_e;

  tt_sweep #(.N_IN(N), .SETTLE(S)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .golden(golden),
    .x_out(x_out), .y_in(y_in), .busy(busy), .done(done), .tt(tt), .match(match),
    .mismatch_cnt(cnt), .first_fail_idx(ffi), .first_fail_vld(ffv)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // block under sweep: a pure lookup table
  always_comb y_in = blk_tt[x_out];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // expected result after the first n vectors have been sampled
  function automatic exp_t model(input logic [31:0] blk, input logic [31:0] gold,
                                 input int n, input int dcyc);
    exp_t        e;
    logic [63:0] m;
    logic [31:0] diff;
    m      = (64'd1 << n) - 64'd1;
    diff   = (blk ^ gold) & m[31:0];
    e.tt   = blk & m[31:0];
    e.cnt  = $countones(diff);
    e.ffv  = (diff != 0);
    e.ffi  = 0;
    for (int i = NV - 1; i >= 0; i--) if (diff[i]) e.ffi = i;
    e.dcyc = dcyc;
    return e;
  endfunction

  always @(negedge clk) begin
    if (rst_n) begin
      m_run  = exp_active && cyc > exp_start && cyc <= exp_start + NV*S;
      m_done = exp_active && cyc == exp_start + NV*S + 1;
      m_x    = m_run ? (cyc - exp_start - 1) / S : 0;
      chk("x_out", 64'(x_out), 64'(m_x));
      chk("busy", 64'(busy), 64'(m_run || m_done));
      chk("done", 64'(done), 64'(m_done));
      if (m_run) chk("match_during_run", 64'(match), 64'd0);
      if (done) begin
        if (sbq.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL sb_empty: got done=1 expected no pending sweep (cycle %0d)", cyc);
        end else begin
          m_e = sbq.pop_front();
          chk("done_cycle", 64'(cyc), 64'(m_e.dcyc));
          chk("tt", 64'(tt), 64'(m_e.tt));
          chk("mismatch_cnt", 64'(cnt), 64'(m_e.cnt));
          chk("match", 64'(match), 64'(m_e.cnt == 0));
          chk("first_fail_vld", 64'(ffv), 64'(m_e.ffv));
          if (m_e.ffv) chk("first_fail_idx", 64'(ffi), 64'(m_e.ffi));
        end
      end
    end
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_x_out"}, 64'(x_out), 64'd0);
    chk({tag, "_tt"}, 64'(tt), 64'd0);
    chk({tag, "_cnt"}, 64'(cnt), 64'd0);
    chk({tag, "_ffi"}, 64'(ffi), 64'd0);
    chk({tag, "_ffv"}, 64'(ffv), 64'd0);
    chk({tag, "_match"}, 64'(match), 64'd0);
    chk({tag, "_busy"}, 64'(busy), 64'd0);
    chk({tag, "_done"}, 64'(done), 64'd0);
  endtask

  task automatic begin_sweep(input logic [31:0] blk, input logic [31:0] gold,
                             input bit push, input bit with_abort);
    blk_tt     = blk;
    golden     = gold;
    start      = 1'b1;
    abort      = with_abort;
    exp_start  = cyc;
    exp_active = 1'b1;
    if (push) sbq.push_back(model(blk, gold, NV, cyc + 1 + NV*S));
    wait_cyc(1);
    start = 1'b0;
    abort = 1'b0;
  endtask

  // mode 0 plain, 1 restart attempt + golden change, 2 abort in DONE, 3 abort with start
  task automatic sweep(input logic [31:0] blk, input logic [31:0] gold, input int mode);
    exp_t e;
    e = model(blk, gold, NV, 0);
    begin_sweep(blk, gold, 1'b1, mode == 3);
    for (int k = 1; k <= NV*S + 1; k++) begin
      if (mode == 1 && k == 10) start = 1'b1;
      if (mode == 1 && k == 11) start = 1'b0;
      if (mode == 1 && k == 12) golden = ~gold;
      if (mode == 2 && k == NV*S + 1) abort = 1'b1;
      wait_cyc(1);
    end
    abort = 1'b0;
    chk("sb_drained", 64'(sbq.size()), 64'd0);
    golden = $urandom;
    wait_cyc(3);
    chk("hold_tt", 64'(tt), 64'(e.tt));
    chk("hold_cnt", 64'(cnt), 64'(e.cnt));
    chk("hold_match", 64'(match), 64'(e.cnt == 0));
  endtask

  initial begin
    logic [31:0] blk, gold, mask;
    exp_t        e;

    #1 rst_n = 1'b0;
    #2 check_all_zero("reset");
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;

    abort = 1'b1;
    wait_cyc(2);
    abort = 1'b0;
    wait_cyc(2);

    sweep(32'hA5C3_0F96, 32'hA5C3_0F96, 0);
    sweep(32'hA5C3_0F96, 32'hA5C3_0F96 ^ 32'h0002_0008, 1);
    blk = $urandom;
    sweep(blk, blk ^ 32'h8000_0000, 2);
    blk = $urandom;
    sweep(blk, $urandom, 3);

    // abort at offset 20: only vectors whose last settle edge precedes it are captured
    blk  = $urandom;
    gold = blk ^ 32'h0000_0031;
    begin_sweep(blk, gold, 1'b0, 1'b0);
    wait_cyc(19);
    abort = 1'b1;
    wait_cyc(1);
    abort      = 1'b0;
    exp_active = 1'b0;
    wait_cyc(2);
    e = model(blk, gold, 19 / S, 0);
    chk("abort_tt", 64'(tt), 64'(e.tt));
    chk("abort_cnt", 64'(cnt), 64'(e.cnt));
    chk("abort_ffv", 64'(ffv), 64'(e.ffv));
    if (e.ffv) chk("abort_ffi", 64'(ffi), 64'(e.ffi));
    chk("abort_match", 64'(match), 64'd0);
    chk("abort_busy", 64'(busy), 64'd0);

    // asynchronous reset mid-sweep
    blk = $urandom | 32'h0000_0001;
    begin_sweep(blk, ~blk, 1'b1, 1'b0);
    wait_cyc(14);
    rst_n      = 1'b0;
    exp_active = 1'b0;
    sbq.delete();
    #1 check_all_zero("midreset");
    wait_cyc(2);
    rst_n = 1'b1;
    wait_cyc(3);
    sweep(32'hA5C3_0F96, 32'hA5C3_0F96, 0);

    for (int i = 0; i < 4; i++) begin
      blk = $urandom;
      case (i)
        0:       mask = 32'h0;
        1:       mask = 32'h1 << $urandom_range(31, 0);
        2:       mask = $urandom;
        default: mask = 32'hFFFF_FFFF;
      endcase
      sweep(blk, blk ^ mask, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish before 200000");
    $fatal(1);
  end

endmodule

// File: doc/tt_sweep.md
TT_SWEEP -- requirements
Module: tt_sweep

Interface
REQ-001 Parameter N_IN, default 5: number of inputs of the combinational block under sweep; legal values 1..6.
REQ-002 Parameter SETTLE, default 1: cycles each input vector is held before y_in is sampled; legal values 1..15.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 start  input  1  request a full sweep; acted on only in IDLE.
REQ-006 abort  input  1  synchronous cancel of a running sweep.
REQ-007 golden  input  2**N_IN  expected truth table; bit i is the expected output for input vector i.
REQ-008 x_out  output  N_IN  vector driven to the block under sweep; x_out[0] = x0 (LSB).
REQ-009 y_in  input  1  output y0 of the block under sweep.
REQ-010 busy  output  1  high while a sweep is in progress.
REQ-011 done  output  1  one-cycle pulse at sweep completion.
REQ-012 tt  output  2**N_IN  captured truth table; bit i = y_in sampled for vector i.
REQ-013 match  output  1  high when the last completed sweep had zero mismatches.
REQ-014 mismatch_cnt  output  N_IN+1  number of vectors where y_in != golden bit.
REQ-015 first_fail_idx  output  N_IN  lowest vector index that mismatched.
REQ-016 first_fail_vld  output  1  high when first_fail_idx is meaningful.

Function
REQ-017 FSM states: IDLE, RUN, DONE.
REQ-018 In IDLE with start=1 at edge k:
- golden is latched into an internal copy.
- tt, mismatch_cnt and first_fail_vld are cleared, and match is driven 0.
- The vector index and settle counter are set to 0.
- The state becomes RUN in cycle k+1.
REQ-019 In RUN, x_out equals the current vector index; each index is held for exactly SETTLE cycles.
REQ-020 On the edge ending the SETTLE-th cycle of index i:
- tt[i] <= y_in.
- If y_in != latched golden[i], mismatch_cnt increments.
- If y_in != latched golden[i] and first_fail_vld=0, first_fail_idx <= i and first_fail_vld <= 1.
REQ-021 After sampling index 2**N_IN-1, the state becomes DONE with no index wrap; otherwise the index increments by 1 and the settle counter restarts at 0.
REQ-022 DONE lasts one cycle with done=1, then returns to IDLE; with start=k, done is high in cycle k+1+(2**N_IN)*SETTLE.
REQ-023 In the cycle done=1, match = (mismatch_cnt==0); tt, match, mismatch_cnt, first_fail_idx and first_fail_vld hold until the next accepted start or reset.
REQ-024 busy = 1 in RUN and DONE, 0 in IDLE.
REQ-025 start while busy=1 is ignored, with no restart and no latching of golden.
REQ-026 Changes on golden during RUN have no effect; only the latched copy is compared.
REQ-027 abort=1 in RUN:
- The next state is IDLE, done is not pulsed, and match stays 0.
- tt and the counters retain their partial values.
- abort has priority over a same-cycle final sample.
REQ-028 abort in IDLE or DONE is ignored; in DONE, done still pulses.
REQ-029 mismatch_cnt cannot overflow: its maximum is 2**N_IN, which fits in N_IN+1 bits.
REQ-030 x_out = 0 whenever the state is not RUN.

Reset
REQ-031 With rst_n=0, asynchronously and at any time, including mid-sweep:
- The state becomes IDLE.
- x_out, tt, latched golden, mismatch_cnt, first_fail_idx and the index are all 0.
- busy, done, match and first_fail_vld are all 0.
REQ-032 After rst_n deasserts, the block waits for start; no sweep begins without start.

Verification
REQ-033 N_IN=5, SETTLE=1, y_in driven by a model equal to golden=32'hA5C3_0F96, start at cycle 0 -> x_out counts 0..31 in cycles 1..32, done=1 in cycle 33, tt=32'hA5C3_0F96, match=1, mismatch_cnt=0, first_fail_vld=0.
REQ-034 Same model, golden with bits 3 and 17 inverted -> done in cycle 33, match=0, mismatch_cnt=2, first_fail_idx=3, first_fail_vld=1, tt still 32'hA5C3_0F96.
REQ-035 SETTLE=3, start at cycle 0 -> each x_out value is held 3 cycles and done=1 in cycle 97.
REQ-036 start pulsed again at cycle 10 of a running sweep, with golden changed at cycle 12 -> no restart, done still in cycle 33, comparison against the golden latched at cycle 0.
REQ-037 rst_n low at cycle 15 of a sweep -> all outputs 0 immediately (asynchronous); a fresh start after release produces a correct full sweep.
REQ-038 abort=1 at cycle 20 -> the state is IDLE at cycle 21, done never pulses, busy=0, tt[18:0] hold the captured values, and tt[31:19] stay 0.
